// File: rtl/tone_decoder.sv
// ---------------------------------------------------------------------------
// tone_decoder
//
// Receive-side counterpart of the button-driven tone generator. A single-bit
// square wave is synchronised, glitch-filtered and timed rising edge to
// rising edge in prescaled clock ticks. Each completed period is classified
// against the four note windows (D/E/G/A). A small FSM locks onto a note
// after CONFIRM consecutive matching periods and drops it again after
// CONFIRM consecutive non-matching periods.
//
// Note codes match the generator's button encoding:
//   0 = none, 1 = D, 2 = E, 3 = G, 4 = A
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   ain           in   asynchronous tone input
//   note          out  decoded note code (0 while not locked)
//   note_valid    out  high while locked on a note
//   period        out  last completed period measurement, in ticks
//   period_strobe out  one-cycle pulse when period updates
// ---------------------------------------------------------------------------
module tone_decoder #(
    parameter int DIV     = 1,     // clk cycles per measurement tick
    parameter int FILT    = 4,     // glitch-filter length in clk cycles (>=1)
    parameter int PW      = 12,    // period counter / output width
    parameter int P_D     = 1330,  // nominal D period in ticks
    parameter int P_E     = 1186,  // nominal E period in ticks
    parameter int P_G     = 996,   // nominal G period in ticks
    parameter int P_A     = 888,   // nominal A period in ticks
    parameter int TOL     = 16,    // inclusive match tolerance in ticks
    parameter int CONFIRM = 3      // consecutive periods to lock / unlock
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ain,
    output logic [2:0]    note,
    output logic          note_valid,
    output logic [PW-1:0] period,
    output logic          period_strobe
);

    // -----------------------------------------------------------------------
    // Local widths and constants
    // -----------------------------------------------------------------------
    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int DW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int MW = $clog2(CONFIRM + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [MW-1:0] CONF_M    = MW'(CONFIRM);
    localparam logic [PW-1:0] MAXP      = '1;

    localparam logic [1:0] SILENT  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    // -----------------------------------------------------------------------
    // Input path: 2-FF synchroniser followed by a persistence filter.
    // ain_f only follows ain_s once ain_s has disagreed with it for FILT
    // consecutive cycles, so short pulses never reach the edge detector.
    // -----------------------------------------------------------------------
    logic [1:0]    sync_pipe;
    logic          ain_s;
    logic          ain_f;
    logic          ain_f_d;
    logic [FW-1:0] flt_cnt;
    logic          rise;

    assign ain_s = sync_pipe[1];
    assign rise  = ain_f & ~ain_f_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            flt_cnt   <= '0;
            ain_f     <= 1'b0;
            ain_f_d   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], ain};
            ain_f_d   <= ain_f;
            if (ain_s != ain_f) begin
                if (flt_cnt == FILT_LAST) begin
                    ain_f   <= ain_s;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FW'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Period measurement
    // -----------------------------------------------------------------------
    logic [DW-1:0] pre_cnt;
    logic          tick;
    logic [PW-1:0] cnt;
    logic          armed;
    logic          cnt_sat;
    logic          meas;        // rise that closes a valid period
    logic          first_edge;  // rise that only (re)starts timing
    logic          timeout;     // counter saturated without an edge

    // Free-running prescaler; edges do not realign it.
    assign tick = (pre_cnt == '0);

    assign cnt_sat    = (cnt == MAXP);
    assign meas       = rise &  armed & ~cnt_sat;
    assign first_edge = rise & (~armed | cnt_sat);
    assign timeout    = ~rise & cnt_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt       <= '0;
            cnt           <= '0;
            armed         <= 1'b0;
            period        <= '0;
            period_strobe <= 1'b0;
        end else begin
            period_strobe <= 1'b0;

            if (pre_cnt == DIV_LAST) pre_cnt <= '0;
            else                     pre_cnt <= pre_cnt + DW'(1);

            if (rise) begin
                // cnt always restarts from zero on an edge; a tick landing
                // in the edge cycle still belongs to the period being
                // closed, so it is folded into the reported value.
                cnt <= '0;
                if (meas) begin
                    period        <= cnt + PW'(tick);
                    period_strobe <= 1'b1;
                end else begin
                    armed <= 1'b1;
                end
            end else if (timeout) begin
                armed <= 1'b0;
            end else if (tick) begin
                cnt <= cnt + PW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Classification of the registered period against the note windows
    // -----------------------------------------------------------------------
    function automatic logic in_win(input logic [PW-1:0] p, input int nom);
        int pi;
        pi = int'({1'b0, p});
        return (pi + TOL >= nom) && (pi <= nom + TOL);
    endfunction

    logic [2:0] cand;

    always_comb begin
        cand = 3'd0;
        if      (in_win(period, P_D)) cand = 3'd1;
        else if (in_win(period, P_E)) cand = 3'd2;
        else if (in_win(period, P_G)) cand = 3'd3;
        else if (in_win(period, P_A)) cand = 3'd4;
    end

    // -----------------------------------------------------------------------
    // Lock tracking
    // -----------------------------------------------------------------------
    logic [1:0]    state;
    logic [2:0]    prev_cand;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] miss_cnt;
    logic [MW-1:0] match_nxt;
    logic [MW-1:0] miss_nxt;

    // A run of equal non-zero candidates extends; anything else restarts
    // the run at 1 (new non-zero candidate) or 0 (no candidate).
    always_comb begin
        match_nxt = MW'(cand != 3'd0);
        if (cand != 3'd0 && cand == prev_cand) match_nxt = match_cnt + MW'(1);
        miss_nxt = miss_cnt + MW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SILENT;
            prev_cand  <= 3'd0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            note       <= 3'd0;
            note_valid <= 1'b0;
        end else begin
            if (period_strobe) begin
                case (state)
                    ACQUIRE: begin
                        match_cnt <= match_nxt;
                        prev_cand <= cand;
                        if (match_nxt == CONF_M) begin
                            state      <= LOCKED;
                            note       <= cand;
                            note_valid <= 1'b1;
                            miss_cnt   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (cand == note) begin
                            miss_cnt <= '0;
                        end else if (miss_nxt == CONF_M) begin
                            // Drop the note and seed acquisition with the
                            // candidate that caused the final miss.
                            state      <= ACQUIRE;
                            note       <= 3'd0;
                            note_valid <= 1'b0;
                            miss_cnt   <= '0;
                            match_cnt  <= MW'(cand != 3'd0);
                            prev_cand  <= cand;
                        end else begin
                            miss_cnt <= miss_nxt;
                        end
                    end
                    default: ;
                endcase
            end

            // Edge restarts and timeouts override any strobe update above.
            if (first_edge) begin
                state      <= ACQUIRE;
                note       <= 3'd0;
                note_valid <= 1'b0;
                prev_cand  <= 3'd0;
                match_cnt  <= '0;
                miss_cnt   <= '0;
            end else if (timeout) begin
                state      <= SILENT;
                note       <= 3'd0;
                note_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// ---------------------------------------------------------------------------
// tb_tone_decoder
//
// Self-checking bench for tone_decoder with default parameters. The stimulus
// is built one full period at a time; every generated rising edge is fed to
// a period-level reference model that predicts which periods get strobed and
// what note/note_valid must read one clk after each strobe.
// ---------------------------------------------------------------------------
module tb_tone_decoder;
    localparam int MAXP    = 4095;
    localparam int TOL     = 16;
    localparam int CONFIRM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ain = 1'b0;
    logic [2:0]  note;
    logic        note_valid;
    logic [11:0] period;
    logic        period_strobe;

    tone_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ain           (ain),
        .note          (note),
        .note_valid    (note_valid),
        .period        (period),
        .period_strobe (period_strobe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // ---------------- reference model (period-level) ----------------
    int exp_q[$];
    int hist[$];
    bit m_armed = 0;
    int m_state = 0;        // 0 silent, 1 acquiring, 2 locked
    int m_note = 0;
    bit m_valid = 0;
    int misses = 0;
    int last_rise = 0;
    int last_strobe_cyc = 0;

    function automatic int nominal(input int c);
        case (c)
            1: return 1330;
            2: return 1186;
            3: return 996;
            4: return 888;
            default: return 0;
        endcase
    endfunction

    function automatic int classify(input int p);
        for (int c = 1; c <= 4; c++)
            if (p >= nominal(c) - TOL && p <= nominal(c) + TOL) return c;
        return 0;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_state = 0; m_note = 0; m_valid = 0;
        misses = 0; hist.delete(); exp_q.delete();
    endtask

    // Called at the moment the bench drives a clean rising edge.
    task automatic model_rise();
        int gap;
        gap = cyc - last_rise;
        if (m_armed && gap <= MAXP) begin
            exp_q.push_back(gap);
        end else begin
            m_armed = 1; m_state = 1; m_note = 0; m_valid = 0;
            misses = 0; hist.delete();
        end
        last_rise = cyc;
    endtask

    // Locks once the last CONFIRM candidates seen while acquiring are one
    // and the same note; unlocks after CONFIRM straight misses.
    task automatic model_strobe(input int p);
        int c;
        bit same;
        c = classify(p);
        if (m_state == 1) begin
            hist.push_back(c);
            if (hist.size() >= CONFIRM) begin
                same = (c != 0);
                for (int k = hist.size() - CONFIRM; k < hist.size(); k++)
                    if (hist[k] != c) same = 0;
                if (same) begin
                    m_state = 2; m_note = c; m_valid = 1; misses = 0;
                end
            end
        end else if (m_state == 2) begin
            if (c == m_note) misses = 0;
            else begin
                misses++;
                if (misses == CONFIRM) begin
                    m_state = 1; m_note = 0; m_valid = 0; misses = 0;
                    hist.delete(); hist.push_back(c);
                end
            end
        end
    endtask

    // ---------------- strobe monitor ----------------
    initial begin : mon
        int p;
        forever begin
            @(negedge clk);
            if (rst_n && period_strobe) begin
                last_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexp_strobe", 1, 0);
                end else begin
                    p = exp_q.pop_front();
                    chk("period", int'(period), p);
                    model_strobe(p);
                    @(negedge clk);
                    chk("note", int'(note), m_note);
                    chk("valid", int'(note_valid), int'(m_valid));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_period(input int p, input int hi);
        @(negedge clk);
        ain = 1'b1;
        model_rise();
        repeat (hi) @(negedge clk);
        ain = 1'b0;
        repeat (p - hi - 1) @(negedge clk);
    endtask

    task automatic send_n(input int p, input int n);
        for (int i = 0; i < n; i++) send_period(p, p / 2);
    endtask

    task automatic glitch(input int p, input int w);
        @(negedge clk);
        ain = 1'b1;
        repeat (w) @(negedge clk);
        ain = 1'b0;
        repeat (p - w - 1) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_note"},   int'(note), 0);
        chk({tag, "_valid"},  int'(note_valid), 0);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_strobe"}, int'(period_strobe), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int w, code, run, p, hi;

        // 1. reset with a toggling input
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ain = ~ain;
        end
        ain = 1'b0;
        @(negedge clk);
        chk_zero("rst");
        model_reset();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 2. lock on D
        send_n(1330, 5);
        chk("lockD_note", int'(note), 1);
        chk("lockD_valid", int'(note_valid), 1);

        // 3. E window edges
        send_n(1202, 6);
        chk("e_hi_note", int'(note), 2);
        send_n(1203, 6);
        chk("e_out_valid", int'(note_valid), 0);
        chk("e_out_period", int'(period), 1203);
        send_n(1170, 5);
        chk("e_lo_note", int'(note), 2);

        // 4. G then change to A
        send_n(996, 6);
        chk("lockG_note", int'(note), 3);
        send_n(888, 7);
        chk("lockA_note", int'(note), 4);
        chk("lockA_valid", int'(note_valid), 1);

        // 5. timeout with input held low
        w = 0;
        while (note_valid && w < 6000) begin
            @(negedge clk);
            w++;
        end
        chk("to_dropped", int'(note_valid), 0);
        chk("to_delay", cyc - last_strobe_cyc, MAXP + 1);
        chk("to_note", int'(note), 0);
        chk("to_period", int'(period), 888);
        send_period(888, 444);          // lone edge: only re-arms
        repeat (1200) @(negedge clk);
        chk("lone_valid", int'(note_valid), 0);
        chk("lone_period", int'(period), 888);

        // 6. glitch rejection, then reset while locked
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) glitch(900, 2);
        chk("glitch_valid", int'(note_valid), 0);
        chk("glitch_period", int'(period), 0);
        send_n(888, 5);
        chk("prerst_note", int'(note), 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        model_reset();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // randomized runs of notes, jitter and duty cycle
        for (int r = 0; r < 7; r++) begin
            code = $urandom_range(0, 4);
            run  = $urandom_range(2, 5);
            for (int i = 0; i < run; i++) begin
                if (code == 0) p = $urandom_range(700, 1500);
                else           p = nominal(code) - TOL - 3 + $urandom_range(0, 2 * TOL + 6);
                hi = $urandom_range(20, p - 20);
                send_period(p, hi);
            end
        end
        repeat (20) @(negedge clk);

        chk("q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
